// File: rtl/pc_gen.sv
// Registered program-counter generator: sequential/branch/jump next-PC selection
// with stall, sticky halt/resume, misaligned-target trapping and retired-instruction count.
module pc_gen #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int unsigned IMM_SHIFT = 1,
  parameter int unsigned INC = 4,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             branch_taken_i,
  input  logic             jump_reg_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  alu_result_i,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_incr_o,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  bad_target_o,
  output logic [CNT_W-1:0] instret_o
);

  // state  | meaning
  // RUN    | fetching and retiring instructions
  // HALTED | pc frozen until resume; halt instruction not yet retired
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [XLEN-1:0]  INC_X   = XLEN'(INC);
  localparam logic [XLEN-1:0]  LSB_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  bad_target_q, bad_target_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  pc_incr;
  logic [XLEN-1:0]  target;
  logic             has_target;
  logic             target_bad;

  assign pc_incr    = pc_q + INC_X;
  assign target     = jump_reg_i ? (alu_result_i & LSB_CLR) : (pc_q + (imm_i << IMM_SHIFT));
  assign has_target = jump_reg_i | branch_taken_i;
  assign target_bad = |target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_VECTOR;
      bad_target_q <= '0;
      misalign_q   <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bad_target_q <= bad_target_d;
      misalign_q   <= misalign_d;
      instret_q    <= instret_d;
    end
  end

  // misalign defaults low so a stalled or ordinary edge ends the trap pulse
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bad_target_d = bad_target_q;
    misalign_d   = 1'b0;
    instret_d    = instret_q;
    if (!stall_i) begin
      case (state_q)
        RUN: begin
          if (has_target) begin
            if (target_bad) begin
              pc_d         = TRAP_VECTOR;
              bad_target_d = target;
              misalign_d   = 1'b1;
            end else begin
              pc_d      = target;
              instret_d = instret_q + CNT_ONE;
            end
          end else if (halt_i) begin
            state_d = HALTED;
          end else begin
            pc_d      = pc_incr;
            instret_d = instret_q + CNT_ONE;
          end
        end
        HALTED: begin
          if (resume_i) begin
            state_d   = RUN;
            pc_d      = pc_incr;
            instret_d = instret_q + CNT_ONE;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    pc_o         = pc_q;
    pc_incr_o    = pc_incr;
    halted_o     = (state_q == HALTED);
    misalign_o   = misalign_q;
    bad_target_o = bad_target_q;
    instret_o    = instret_q;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a behavioural model pushes expected post-edge state
// per driven cycle, popped and compared one time unit after the rising edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, halt, resume, branch_taken, jump_reg;
  logic [31:0] imm, alu_result;
  logic [31:0] pc, pc_incr, bad_target;
  logic        halted, misalign;
  logic [63:0] instret;

  typedef struct packed {
    logic [31:0] pc;
    logic        halted;
    logic        misalign;
    logic [31:0] bad;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] m_pc, m_bad;
  logic        m_halted, m_mis;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .branch_taken_i(branch_taken), .jump_reg_i(jump_reg), .imm_i(imm),
    .alu_result_i(alu_result), .pc_o(pc), .pc_incr_o(pc_incr), .halted_o(halted),
    .misalign_o(misalign), .bad_target_o(bad_target), .instret_o(instret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_bad = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 64'd0;
    sb_q.delete();
  endtask

  task automatic model_edge(input logic s, h, r, br, jr, input logic [31:0] im, al);
    logic [31:0] t;
    logic        pulse;
    pulse = 1'b0;
    if (!s) begin
      if (m_halted) begin
        if (r) begin m_halted = 1'b0; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 64'd1; end
      end else if (jr || br) begin
        t = jr ? {al[31:1], 1'b0} : m_pc + {im[30:0], 1'b0};
        if (t[1:0] != 2'b00) begin
          m_pc = 32'h100; m_bad = t; pulse = 1'b1;
        end else begin
          m_pc = t; m_cnt = m_cnt + 64'd1;
        end
      end else if (h) begin
        m_halted = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 64'd1;
      end
    end
    m_mis = pulse;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".pc"}, {32'h0, pc}, {32'h0, e.pc});
    check({tag, ".pc_incr"}, {32'h0, pc_incr}, {32'h0, e.pc + 32'd4});
    check({tag, ".halted"}, {63'h0, halted}, {63'h0, e.halted});
    check({tag, ".misalign"}, {63'h0, misalign}, {63'h0, e.misalign});
    check({tag, ".bad_target"}, {32'h0, bad_target}, {32'h0, e.bad});
    check({tag, ".instret"}, instret, e.cnt);
  endtask

  task automatic step(input string tag, input logic s, h, r, br, jr,
                      input logic [31:0] im, al);
    stall = s; halt = h; resume = r; branch_taken = br; jump_reg = jr;
    imm = im; alu_result = al;
    model_edge(s, h, r, br, jr, im, al);
    sb_q.push_back('{pc: m_pc, halted: m_halted, misalign: m_mis, bad: m_bad, cnt: m_cnt});
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"}, {32'h0, pc}, 64'h0);
    check({tag, ".halted"}, {63'h0, halted}, 64'h0);
    check({tag, ".misalign"}, {63'h0, misalign}, 64'h0);
    check({tag, ".bad_target"}, {32'h0, bad_target}, 64'h0);
    check({tag, ".instret"}, instret, 64'h0);
  endtask

  task automatic do_reset();
    stall = 0; halt = 0; resume = 0; branch_taken = 0; jump_reg = 0;
    imm = 0; alu_result = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    idle("free1"); idle("free2"); idle("free3");
    check("free.instret3", instret, 64'd3);
    idle("to_0x10");
    step("branch", 0, 0, 0, 1, 0, 32'h8, 32'h0);
    step("jump", 0, 0, 0, 0, 1, 32'h0, 32'h41);
    step("misalign_br", 0, 0, 0, 1, 0, 32'h1, 32'h0);
    check("trap.pc", {32'h0, pc}, 64'h100);
    check("trap.bad", {32'h0, bad_target}, 64'h42);
    idle("pulse_end");
    step("jr_beats_br", 0, 1, 0, 1, 1, 32'h40, 32'h200);
    step("br_beats_halt", 0, 1, 0, 1, 0, 32'h10, 32'h0);
    step("misalign_jr", 0, 0, 0, 0, 1, 32'h0, 32'h0000_0303);
    step("stall_after_trap", 1, 0, 0, 0, 0, 32'h0, 32'h0);
    idle("resume_in_run");

    do_reset();
    idle("h1"); idle("h2");
    step("halt", 0, 1, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step("halted_hold", 0, 1, 0, 1, 0, 32'h8, 32'h0);
    step("resume", 0, 0, 1, 0, 0, 32'h0, 32'h0);
    check("resume.pc", {32'h0, pc}, 64'hC);
    step("halt2", 0, 1, 0, 0, 0, 32'h0, 32'h0);
    step("halt_and_resume", 0, 1, 1, 0, 0, 32'h0, 32'h0);
    step("halt3", 0, 1, 0, 0, 0, 32'h0, 32'h0);
    step("stall_in_halt", 1, 0, 1, 0, 0, 32'h0, 32'h0);
    step("resume3", 0, 0, 1, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 3; i++) step("stall_jump", 1, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC);
    step("jump_top", 0, 0, 0, 0, 1, 32'h0, 32'hFFFF_FFFC);
    idle("wrap");
    check("wrap.pc", {32'h0, pc}, 64'h0);
    step("neg_branch", 0, 0, 0, 1, 0, 32'hFFFF_FFFE, 32'h0);

    for (int i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) == 0), $urandom_range(0, 255), $urandom);
    end

    do_reset();
    for (int i = 0; i < 7; i++) idle("pre_async");
    step("async_halt", 0, 1, 0, 0, 0, 32'h0, 32'h0);
    check("async.instret7", instret, 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Registered program-counter generator for the single-cycle RISC-V core. It holds the architectural PC and selects the next PC from sequential increment, PC-relative branch, or register jump. It adds what the combinational next-PC logic lacks: stall, a sticky halt state with resume, misaligned-target trapping, and a retired-instruction counter. It sits between the fetch port (drives `pc`) and the execute stage (supplies `branch_taken`, `jump_reg`, `imm`, `alu_result`).

## Interface
- `XLEN`, 32, address/data width
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on misaligned target
- `IMM_SHIFT`, 1, left shift applied to `imm` for branch offset
- `INC`, 4, sequential increment in bytes
- `CNT_W`, 64, width of `instret`

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `stall`  in  1  freeze all state this cycle
- `halt`  in  1  halt request from current instruction
- `resume`  in  1  leave HALTED
- `branch_taken`  in  1  conditional branch resolved taken
- `jump_reg`  in  1  register-indirect jump (JALR)
- `imm`  in  XLEN  branch immediate, unshifted
- `alu_result`  in  XLEN  jump target from ALU
- `pc`  out  XLEN  current PC, registered
- `pc_incr`  out  XLEN  `pc + INC`, combinational
- `halted`  out  1  high in HALTED state, registered
- `misalign`  out  1  one-cycle trap pulse, registered
- `bad_target`  out  XLEN  last faulting target, registered
- `instret`  out  CNT_W  retired-instruction count, registered

## Operation
- States: RUN, HALTED. `halted` = (state == HALTED).
- Candidate target, RUN only, in priority order:
  - `jump_reg`: `{alu_result[XLEN-1:1],1'b0}`.
  - `branch_taken`: `pc + (imm << IMM_SHIFT)`.
- Misalignment check: a candidate target with bits [1:0] != 0 is misaligned. On a misaligned target:
  - `pc` <= TRAP_VECTOR, `bad_target` <= target, `misalign` = 1 next cycle.
  - `instret` is not incremented.
- RUN, each non-stalled edge:
  - jump or branch, aligned: `pc` <= target, `instret`++.
  - Else `halt`: state <= HALTED, `pc` holds, `instret` does not change.
  - Else: `pc` <= `pc_incr`, `instret`++.
- HALTED:
  - `pc` holds; branch, jump and halt inputs are ignored.
  - `resume`: state <= RUN, `pc` <= `pc_incr`, `instret`++ (the halt instruction retires).
- `stall` = 1 overrides everything except reset. No state, PC, counter or `bad_target` change. `misalign` is 0 on the following edge.
- Simultaneous inputs:
  - jump_reg beats branch_taken, which beats halt.
  - `resume` in RUN is ignored.
  - `halt` + `resume` in HALTED means resume.
- Arithmetic is modulo 2^XLEN: `pc_incr` at 32'hFFFF_FFFC wraps to 0. `instret` wraps to 0 at 2^CNT_W.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-halt or mid-trap): `pc`=RESET_VECTOR, state RUN, `halted`=0, `misalign`=0, `bad_target`=0, `instret`=0. First update occurs on the first rising edge after `rst_n` deasserts.
- Latencies:
  - All PC updates: inputs sampled at edge N, new `pc` visible after edge N.
  - `misalign` is high for exactly the cycle following the trapping edge.
  - `halted` rises one edge after `halt` is sampled and falls one edge after `resume` is sampled.
- `pc_incr` follows `pc` combinationally with zero latency.
- `bad_target` holds its value until the next trap or reset.

## Test plan
- Reset then 3 free-running cycles -> `pc` = 0, 4, 8, 12; `instret` = 3; `halted` = 0.
- At `pc`=0x10: `branch_taken`=1, `imm`=0x8 -> `pc`=0x20, `instret`+1. At `pc`=0x20: `jump_reg`=1, `alu_result`=0x41 -> `pc`=0x40.
- At `pc`=0x40: `branch_taken`=1, `imm`=0x1 (target 0x42) -> `pc`=0x100, `misalign` pulses 1 cycle, `bad_target`=0x42, `instret` unchanged.
- `halt` at `pc`=0x8 -> `halted`=1, `pc` holds 0x8 for 5 cycles despite `branch_taken`=1. Then `resume` -> `pc`=0xC, `halted`=0, `instret`+1.
- `stall`=1 for 3 cycles with `jump_reg`=1 -> `pc`/`instret` frozen. Then `pc`=0xFFFF_FFFC unstalled -> `pc`=0x0 (wrap).
- Assert `rst_n` low asynchronously mid-HALTED with `instret`=7 -> outputs go to reset values immediately, before the next clock edge.
